// File: rtl/spi_pkg.sv
// Shared types and sizing helpers for the SPI master controller.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_XFER,
    ST_TRAIL,
    ST_GAP,
    ST_HOLD
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // Edge counter must reach 2*data_w (the terminal value), hence the +1.
  function automatic int edge_w(input int data_w);
    return $clog2(2 * data_w + 1);
  endfunction

  localparam int EDGE_W = edge_w(8);

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer: down-counter reloaded from the latched divider, ticking once every clk_div+1 cycles.
module spi_clk_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] period;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      period <= '0;
    end else if (load) begin
      cnt    <= div;
      period <= div;
    end else if (en) begin
      if (cnt == '0) cnt <= period;
      else           cnt <= cnt - 1'b1;
    end
  end

  assign tick = en && (cnt == '0);

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master sequencer: single-byte transfers in all four CPOL/CPHA modes with optional CS hold.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8,
  parameter int NUM_SS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      cpol,
  input  logic                      cpha,
  input  logic [DIV_W-1:0]          clk_div,
  input  logic [$clog2(NUM_SS)-1:0] ss_sel,
  input  logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_last,
  output logic                      ready,
  output logic                      busy,
  output logic [DATA_W-1:0]         rx_data,
  output logic                      rx_valid,
  output logic                      sclk,
  output logic                      mosi,
  input  logic                      miso,
  output logic [NUM_SS-1:0]         ss_n
);

  localparam int EW = edge_w(DATA_W);
  localparam logic [EW-1:0] LAST_EDGE  = EW'(2 * DATA_W);
  localparam logic [EW-1:0] LAST_DRIVE = EW'(2 * DATA_W - 1);

  spi_state_t        state;
  spi_mode_t         mode;
  logic              last_l;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic [EW-1:0]     edge_cnt;
  logic              tick;
  logic              accept;
  logic              lead_edge;
  logic              do_edge;

  assign ready     = (state == ST_IDLE) || (state == ST_HOLD);
  assign busy      = !ready;
  assign accept    = start && ready;
  assign lead_edge = ~edge_cnt[0];
  // The LEAD tick produces edge 0; the tick after the last edge only closes XFER.
  assign do_edge   = tick && ((state == ST_LEAD) ||
                              ((state == ST_XFER) && (edge_cnt != LAST_EDGE)));

  spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .en    (busy),
    .div   (clk_div),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      mode     <= '0;
      last_l   <= 1'b0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      edge_cnt <= '0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      ss_n     <= '1;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          sclk <= cpol;
          ss_n <= '1;
        end
        ST_HOLD: sclk <= mode.cpol;
        ST_LEAD: if (tick) state <= ST_XFER;
        ST_XFER: if (tick && (edge_cnt == LAST_EDGE)) state <= ST_TRAIL;
        ST_TRAIL: begin
          sclk <= mode.cpol;
          if (tick) begin
            rx_data  <= rx_sh;
            rx_valid <= 1'b1;
            if (last_l) begin
              state <= ST_GAP;
              ss_n  <= '1;
            end else begin
              state <= ST_HOLD;
            end
          end
        end
        ST_GAP:  if (tick) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      if (accept) begin
        state    <= ST_LEAD;
        mode     <= '{cpol: cpol, cpha: cpha};
        last_l   <= tx_last;
        edge_cnt <= '0;
        sclk     <= cpol;
        ss_n     <= ~(NUM_SS'(1) << ss_sel);
        // cpha=0 presents the MSB before the first edge, so the shifter starts one bit ahead.
        if (cpha) begin
          tx_sh <= tx_data;
        end else begin
          tx_sh <= {tx_data[DATA_W-2:0], 1'b0};
          mosi  <= tx_data[DATA_W-1];
        end
      end

      if (do_edge) begin
        sclk     <= ~sclk;
        edge_cnt <= edge_cnt + 1'b1;
        if (lead_edge ^ mode.cpha) begin
          rx_sh <= {rx_sh[DATA_W-2:0], miso};
        end else if (mode.cpha || (edge_cnt != LAST_DRIVE)) begin
          mosi  <= tx_sh[DATA_W-1];
          tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: timing, modes, CS hold, dropped starts and mid-transfer reset.
module tb_spi_master_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, cpol, cpha, tx_last;
  logic [7:0] clk_div, tx_data;
  logic [1:0] ss_sel;
  logic       ready, busy, rx_valid, sclk, mosi, miso;
  logic [7:0] rx_data;
  logic [3:0] ss_n;

  int errors = 0;
  int checks = 0;

  logic       loopback = 1'b1;
  logic [7:0] slv_sh = 8'h00;
  logic       slv_bit = 1'b0;
  logic       m_cpol = 1'b0, m_cpha = 1'b0;
  logic [7:0] mosi_cap = 8'h00;
  int         rises = 0, toggles = 0, rx_pulses = 0, ss2_breaks = 0, bad_mosi = 0;
  logic       watch_ss2 = 1'b0, watch_mosi = 1'b0;
  logic       last_mosi = 1'b0, last_sclk = 1'b0;
  int         lat;

  always #5 clk = ~clk;

  spi_master_ctrl #(.DATA_W(8), .DIV_W(8), .NUM_SS(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .cpol     (cpol),
    .cpha     (cpha),
    .clk_div  (clk_div),
    .ss_sel   (ss_sel),
    .tx_data  (tx_data),
    .tx_last  (tx_last),
    .ready    (ready),
    .busy     (busy),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso),
    .ss_n     (ss_n)
  );

  assign miso = loopback ? mosi : slv_bit;

  // Slave model drives its next bit on each leading edge while selected.
  always @(sclk) begin
    if (!loopback && ss_n != 4'hF && sclk == ~m_cpol) begin
      slv_bit = slv_sh[7];
      slv_sh  = {slv_sh[6:0], 1'b0};
    end
    if (ss_n != 4'hF) toggles++;
    if (ss_n != 4'hF && sclk == ~(m_cpol ^ m_cpha)) mosi_cap = {mosi_cap[6:0], mosi};
  end

  always @(posedge sclk) if (ss_n != 4'hF) rises++;

  always @(negedge clk) begin
    if (rx_valid) rx_pulses++;
    if (watch_ss2 && ss_n[2]) ss2_breaks++;
    if (watch_mosi && mosi !== last_mosi && !(last_sclk === 1'b1 && sclk === 1'b0)) bad_mosi++;
    last_mosi = mosi;
    last_sclk = sclk;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns in cycle k+1 where k is the accept cycle.
  task automatic launch(input logic pol, input logic pha, input logic [7:0] div,
                        input logic [1:0] ss, input logic [7:0] tx, input logic last);
    cpol = pol; cpha = pha; clk_div = div; ss_sel = ss; tx_data = tx; tx_last = last;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_rx(input string tag, input int lat0, input int limit, output int lat_o);
    lat_o = lat0;
    while (!rx_valid && lat_o < limit) begin
      step(1);
      lat_o++;
    end
    chk({tag, "_rx_timeout"}, rx_valid, 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cpol = 1'b0; cpha = 1'b0; tx_last = 1'b1;
    clk_div = 8'd0; tx_data = 8'h00; ss_sel = 2'd0;
    step(2);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_ss_n", ss_n, 4'hF);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    step(1);

    // Mode 0, H=1, loopback
    m_cpol = 0; m_cpha = 0; mosi_cap = 0; rises = 0;
    launch(0, 0, 8'd0, 2'd0, 8'hA5, 1);
    chk("m0_ss_lead", ss_n, 4'hE);
    chk("m0_busy", busy, 1);
    step(17);
    chk("m0_rxv_early", rx_valid, 0);
    chk("m0_ss_trail", ss_n, 4'hE);
    step(1);
    chk("m0_rxv", rx_valid, 1);
    chk("m0_rx_data", rx_data, 8'hA5);
    chk("m0_ready_gap", ready, 0);
    chk("m0_rises", rises, 8);
    chk("m0_mosi_cap", mosi_cap, 8'hA5);
    step(1);
    chk("m0_ready_ret", ready, 1);
    chk("m0_ss_rel", ss_n, 4'hF);
    chk("m0_rxv_pulse", rx_valid, 0);

    // Mode 3, H=4, slave returns 0x3C
    loopback = 0; slv_sh = 8'h3C; m_cpol = 1; m_cpha = 1; mosi_cap = 0;
    cpol = 1; cpha = 1;
    step(2);
    chk("m3_idle_sclk", sclk, 1);
    bad_mosi = 0; watch_mosi = 1;
    launch(1, 1, 8'd3, 2'd1, 8'h96, 1);
    step(3);
    chk("m3_sclk_pre_e0", sclk, 1);
    chk("m3_ss_lead", ss_n, 4'hD);
    step(1);
    chk("m3_sclk_e0", sclk, 0);
    step(67);
    chk("m3_rxv_early", rx_valid, 0);
    step(1);
    chk("m3_rxv", rx_valid, 1);
    chk("m3_rx_data", rx_data, 8'h3C);
    chk("m3_mosi_cap", mosi_cap, 8'h96);
    watch_mosi = 0;
    chk("m3_mosi_falling_only", bad_mosi, 0);
    step(20);
    chk("m3_idle_after", sclk, 1);
    chk("m3_ready_after", ready, 1);
    loopback = 1;

    // Mode 1, H=2
    m_cpol = 0; m_cpha = 1; mosi_cap = 0; cpol = 0; cpha = 1;
    step(2);
    launch(0, 1, 8'd1, 2'd3, 8'h81, 1);
    wait_rx("m1", 1, 200, lat);
    chk("m1_lat", lat, 37);
    chk("m1_rx_data", rx_data, 8'h81);
    chk("m1_mosi_cap", mosi_cap, 8'h81);
    step(5);

    // Mode 2, H=2
    m_cpol = 1; m_cpha = 0; mosi_cap = 0; cpol = 1; cpha = 0;
    step(2);
    launch(1, 0, 8'd1, 2'd0, 8'h7E, 1);
    wait_rx("m2", 1, 200, lat);
    chk("m2_lat", lat, 37);
    chk("m2_rx_data", rx_data, 8'h7E);
    chk("m2_mosi_cap", mosi_cap, 8'h7E);
    step(5);

    // Two bytes with CS held on slave 2
    m_cpol = 0; m_cpha = 0; cpol = 0; cpha = 0;
    step(2);
    rx_pulses = 0; ss2_breaks = 0;
    launch(0, 0, 8'd0, 2'd2, 8'h11, 0);
    watch_ss2 = 1;
    wait_rx("hold1", 1, 100, lat);
    chk("hold1_rx_data", rx_data, 8'h11);
    chk("hold1_ready", ready, 1);
    chk("hold1_ss", ss_n, 4'hB);
    step(3);
    chk("hold_ss_kept", ss_n, 4'hB);
    chk("hold_sclk", sclk, 0);
    chk("hold_ready", ready, 1);
    launch(0, 0, 8'd0, 2'd2, 8'h22, 1);
    wait_rx("hold2", 1, 100, lat);
    watch_ss2 = 0;
    chk("hold2_lat", lat, 19);
    chk("hold2_rx_data", rx_data, 8'h22);
    chk("hold_ss2_continuous", ss2_breaks, 0);
    step(1);
    chk("hold2_ss_rel", ss_n, 4'hF);
    chk("hold_pulses", rx_pulses, 2);

    // Start re-pulsed during XFER is dropped
    rx_pulses = 0; mosi_cap = 0;
    launch(0, 0, 8'd1, 2'd0, 8'hC3, 1);
    step(10);
    tx_data = 8'hFF; ss_sel = 2'd1; start = 1'b1;
    step(1);
    start = 1'b0;
    chk("drop_ss", ss_n, 4'hE);
    wait_rx("drop", 12, 200, lat);
    chk("drop_lat", lat, 37);
    chk("drop_rx_data", rx_data, 8'hC3);
    step(50);
    chk("drop_pulses", rx_pulses, 1);
    chk("drop_ready", ready, 1);

    // Reset at the 5th sclk edge
    rx_pulses = 0; toggles = 0;
    launch(0, 0, 8'd0, 2'd0, 8'h99, 1);
    for (int i = 0; i < 40 && toggles < 5; i++) step(1);
    chk("rst5_edges", toggles, 5);
    reset = 1'b1;
    step(1);
    chk("rst5_ss_n", ss_n, 4'hF);
    chk("rst5_sclk", sclk, 0);
    chk("rst5_ready", ready, 1);
    chk("rst5_busy", busy, 0);
    chk("rst5_rxv", rx_valid, 0);
    reset = 1'b0;
    step(40);
    chk("rst5_no_pulse", rx_pulses, 0);
    mosi_cap = 0;
    launch(0, 0, 8'd2, 2'd1, 8'h5A, 1);
    wait_rx("post", 1, 200, lat);
    chk("post_lat", lat, 55);
    chk("post_rx_data", rx_data, 8'h5A);
    chk("post_mosi_cap", mosi_cap, 8'h5A);
    step(5);

    // Maximum divider, H=256
    mosi_cap = 0;
    launch(0, 0, 8'd255, 2'd3, 8'hE7, 1);
    wait_rx("maxdiv", 1, 6000, lat);
    chk("maxdiv_lat", lat, 4609);
    chk("maxdiv_rx_data", rx_data, 8'hE7);
    chk("maxdiv_mosi_cap", mosi_cap, 8'hE7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
